// File: rtl/rt_scan_pkg.sv
// rtl/rt_scan_pkg.sv - shared types, fixed-point format and coordinate conversion for the pixel scanner
// Optional build macro: RT_SCAN_PIXEL_CENTER_EN (adds +0.5 so rays pass through pixel centres)
package rt_scan_pkg;

    localparam int COORD_W = 16;
    localparam int FP_IW   = 16;
    localparam int FP_QW   = 16;
    localparam int FP_WL   = FP_IW + FP_QW;
    localparam int WIDE_W  = COORD_W + FP_QW + 1;

    localparam logic [FP_WL-1:0] FP_MAX = {1'b0, {(FP_WL-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scan_state_t;

    // Offset (if any) is added before the saturation test so x.5 never wraps.
    function automatic logic [FP_WL-1:0] coord_to_fp(input logic [COORD_W-1:0] coord);
        logic [WIDE_W-1:0] wide;
        wide = {1'b0, coord, {FP_QW{1'b0}}};
`ifdef RT_SCAN_PIXEL_CENTER_EN
        wide = wide + (WIDE_W'(1) << (FP_QW - 1));
`endif
        if (wide > WIDE_W'(FP_MAX))
            return FP_MAX;
        return wide[FP_WL-1:0];
    endfunction

endpackage

// File: rtl/rt_credit_counter.sv
// rtl/rt_credit_counter.sv - rays-in-flight counter with credit limit and sticky underflow error
module rt_credit_counter #(
    parameter int CREDITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic has_credit,
    output logic empty,
    output logic err
);

    logic [7:0] in_flight;

    assign has_credit = (in_flight < 8'(CREDITS));
    assign empty      = (in_flight == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            in_flight <= 8'd0;
            err       <= 1'b0;
        end else begin
            if (inc && !dec) begin
                in_flight <= in_flight + 8'd1;
            end else if (dec && !inc) begin
                // An ack with nothing outstanding is a downstream protocol error.
                if (empty)
                    err <= 1'b1;
                else
                    in_flight <= in_flight - 8'd1;
            end
        end
    end

endmodule

// File: rtl/rt_pixel_scanner.sv
// rtl/rt_pixel_scanner.sv - raster-order pixel walker issuing credit-throttled start pulses to the RGU
// Optional build macro: RT_SCAN_PIXEL_CENTER_EN (pixel-centre offset on x/y)
module rt_pixel_scanner
    import rt_scan_pkg::*;
#(
    parameter int CREDITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] img_width,
    input  logic [COORD_W-1:0] img_height,
    input  logic               ray_ack,
    output logic               busy,
    output logic               frame_done,
    output logic               rgu_start,
    output logic [FP_WL-1:0]   x,
    output logic [FP_WL-1:0]   y,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               ack_err
);

    scan_state_t        state;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic               has_credit;
    logic               empty;
    logic               issue;

    // Registered in_flight gates the issue, so a same-cycle ack cannot unlock it.
    assign issue = (state == SCAN) && has_credit;

    rt_credit_counter #(
        .CREDITS(CREDITS)
    ) u_credits (
        .clk       (clk),
        .reset     (reset),
        .inc       (issue),
        .dec       (ray_ack),
        .has_credit(has_credit),
        .empty     (empty),
        .err       (ack_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rgu_start  <= 1'b0;
            x          <= '0;
            y          <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            w          <= '0;
            h          <= '0;
            cx         <= '0;
            cy         <= '0;
        end else begin
            rgu_start  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        w     <= img_width;
                        h     <= img_height;
                        cx    <= '0;
                        cy    <= '0;
                        busy  <= 1'b1;
                        state <= (img_width == '0 || img_height == '0) ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        rgu_start <= 1'b1;
                        pix_x     <= cx;
                        pix_y     <= cy;
                        x         <= coord_to_fp(cx);
                        y         <= coord_to_fp(cy);
                        if (cx == w - COORD_W'(1)) begin
                            cx <= '0;
                            cy <= cy + COORD_W'(1);
                            if (cy == h - COORD_W'(1))
                                state <= DRAIN;
                        end else begin
                            cx <= cx + COORD_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (empty)
                        state <= DONE;
                end
                DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rt_pixel_scanner.sv
// tb/tb_rt_pixel_scanner.sv - directed self-checking bench for rt_pixel_scanner
module tb_rt_pixel_scanner;

`ifdef RT_SCAN_PIXEL_CENTER_EN
    localparam logic [31:0] HALF = 32'h0000_8000;
`else
    localparam logic [31:0] HALF = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic        ray_ack;
    logic        busy;
    logic        frame_done;
    logic        rgu_start;
    logic [31:0] x;
    logic [31:0] y;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic        ack_err;

    logic        auto_ack = 1'b0;
    logic        man_ack  = 1'b0;
    logic [4:0]  ack_pipe = '0;

    int compared = 0;
    int failed   = 0;

    int cyc = 0;
    int issue_cnt = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int ack_cnt = 0;
    int last_ack_cyc = 0;
    int done_cyc = 0;
    int fs_cyc = 0;

    logic [15:0] px_log [256];
    logic [15:0] py_log [256];
    logic [31:0] x_log  [256];
    logic [31:0] y_log  [256];
    int          ic_log [256];

    assign ray_ack = auto_ack ? ack_pipe[4] : man_ack;

    rt_pixel_scanner #(.CREDITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .img_width  (img_width),
        .img_height (img_height),
        .ray_ack    (ray_ack),
        .busy       (busy),
        .frame_done (frame_done),
        .rgu_start  (rgu_start),
        .x          (x),
        .y          (y),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .ack_err    (ack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ack_pipe <= {ack_pipe[3:0], rgu_start};
        if (rgu_start) begin
            px_log[issue_cnt[7:0]] <= pix_x;
            py_log[issue_cnt[7:0]] <= pix_y;
            x_log[issue_cnt[7:0]]  <= x;
            y_log[issue_cnt[7:0]]  <= y;
            ic_log[issue_cnt[7:0]] <= cyc;
            issue_cnt <= issue_cnt + 1;
        end
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (ray_ack) begin
            ack_cnt      <= ack_cnt + 1;
            last_ack_cyc <= cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [15:0] w, input logic [15:0] h);
        img_width   = w;
        img_height  = h;
        frame_start = 1'b1;
        fs_cyc      = cyc;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done_cnt > base) break;
            step(1);
        end
        step(2);
    endtask

    task automatic pulse_ack(input int gap);
        man_ack = 1'b1;
        step(1);
        man_ack = 1'b0;
        step(gap);
    endtask

    initial begin
        int ib;
        int db;
        int bb;
        int ab;

        reset       = 1'b1;
        frame_start = 1'b0;
        img_width   = '0;
        img_height  = '0;
        step(3);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_rgu", rgu_start, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_pix", {pix_x, pix_y}, 0);
        check("rst_ack_err", ack_err, 0);
        reset = 1'b0;
        step(2);

        // 4x2 frame, acks trail issues by ~5 cycles
        auto_ack = 1'b1;
        ib = issue_cnt; db = done_cnt;
        start_frame(16'd4, 16'd2);
        check("t1_busy", busy, 1);
        wait_done(db, 100);
        check("t1_issues", issue_cnt - ib, 8);
        check("t1_latency", ic_log[ib] - fs_cyc, 2);
        check("t1_consecutive", ic_log[ib+7] - ic_log[ib], 7);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_px%0d", i), px_log[ib+i], i % 4);
            check($sformatf("t1_py%0d", i), py_log[ib+i], i / 4);
        end
        check("t1_x_last", x_log[ib+7], 32'h0003_0000 + HALF);
        check("t1_y_last", y_log[ib+7], 32'h0001_0000 + HALF);
        check("t1_done_once", done_cnt - db, 1);
        check("t1_done_after_ack", done_cyc > last_ack_cyc, 1);
        check("t1_busy_end", busy, 0);
        check("t1_ack_err", ack_err, 0);

        // 16x1 frame, credit stall then manual acks
        auto_ack = 1'b0;
        step(8);
        ib = issue_cnt; db = done_cnt;
        start_frame(16'd16, 16'd1);
        step(30);
        check("t2_stall_issues", issue_cnt - ib, 8);
        check("t2_stall_busy", busy, 1);
        for (int i = 0; i < 3; i++) pulse_ack(2);
        step(5);
        check("t2_three_more", issue_cnt - ib, 11);
        for (int i = 0; i < 13; i++) pulse_ack(2);
        wait_done(db, 50);
        check("t2_total_issues", issue_cnt - ib, 16);
        check("t2_done_once", done_cnt - db, 1);
        check("t2_ack_err", ack_err, 0);

        // zero-width frame
        step(8);
        ib = issue_cnt; db = done_cnt; bb = busy_cnt;
        start_frame(16'd0, 16'd5);
        wait_done(db, 20);
        check("t3_no_issue", issue_cnt - ib, 0);
        check("t3_done_once", done_cnt - db, 1);
        check("t3_done_latency", done_cyc - fs_cyc, 2);
        check("t3_busy_cycles", busy_cnt - bb, 1);

        // reset mid-frame, then a clean 2x2 frame
        ib = issue_cnt; db = done_cnt;
        start_frame(16'd4, 16'd4);
        for (int i = 0; i < 20; i++) begin
            if (issue_cnt - ib >= 3) break;
            step(1);
        end
        check("t4_pre_reset_issues", issue_cnt - ib >= 3, 1);
        reset = 1'b1;
        step(1);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_rgu", rgu_start, 0);
        check("t4_rst_done", frame_done, 0);
        check("t4_rst_xy", {x, y}, 0);
        check("t4_rst_pix", {pix_x, pix_y}, 0);
        reset = 1'b0;
        step(8);
        check("t4_no_done", done_cnt - db, 0);
        auto_ack = 1'b1;
        ib = issue_cnt; db = done_cnt;
        start_frame(16'd2, 16'd2);
        wait_done(db, 60);
        check("t4_issues", issue_cnt - ib, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_px%0d", i), px_log[ib+i], i % 2);
            check($sformatf("t4_py%0d", i), py_log[ib+i], i / 2);
        end
        check("t4_done_once", done_cnt - db, 1);
        check("t4_ack_err", ack_err, 0);

        // stray ack in IDLE, then frame_start ignored while busy
        auto_ack = 1'b0;
        step(8);
        ab = ack_cnt;
        pulse_ack(1);
        check("t5_stray_seen", ack_cnt - ab, 1);
        check("t5_ack_err_set", ack_err, 1);
        step(5);
        check("t5_ack_err_sticky", ack_err, 1);
        auto_ack = 1'b1;
        ib = issue_cnt; db = done_cnt;
        start_frame(16'd3, 16'd1);
        img_width   = 16'd7;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        wait_done(db, 60);
        check("t5_issues", issue_cnt - ib, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t5_px%0d", i), px_log[ib+i], i);
        check("t5_done_once", done_cnt - db, 1);
        check("t5_ack_err_still", ack_err, 1);
        check("t5_busy_end", busy, 0);

        // fixed-point encoding of x for a 2x1 frame, and saturation
        step(8);
        ib = issue_cnt; db = done_cnt;
        start_frame(16'd2, 16'd1);
        wait_done(db, 40);
        check("t6_issues", issue_cnt - ib, 2);
        check("t6_x0", x_log[ib], 32'h0000_0000 + HALF);
        check("t6_x1", x_log[ib+1], 32'h0001_0000 + HALF);
        check("t6_y0", y_log[ib], 32'h0000_0000 + HALF);
        check("t6_px0", px_log[ib], 0);
        check("t6_px1", px_log[ib+1], 1);
        check("sat_max_ok", rt_scan_pkg::coord_to_fp(16'd32767), 32'h7FFF_0000 + HALF);
        check("sat_first", rt_scan_pkg::coord_to_fp(16'd32768), 32'h7FFF_FFFF);
        check("sat_top", rt_scan_pkg::coord_to_fp(16'd65535), 32'h7FFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
